// File: rtl/seq_divider_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_divider_pkg                                                  |
// | State encodings and handshake levels shared by divider and ALU.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package seq_divider_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'd0,
    DivByZero = 2'd1,
    DivOn     = 2'd2,
    DivEnd    = 2'd3
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/div_trial_sub.sv
`default_nettype none
// +------------------------------------------------------------------+
// | div_trial_sub                                                    |
// | Combinational (WIDTH+1)-bit trial subtract for the divider.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module div_trial_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_minuend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_ge
);

  // The difference is only consumed when o_ge is set, and then it is
  // strictly below the divisor, so its low WIDTH bits carry all of it.
  assign o_ge   = (i_minuend >= {1'b0, i_divisor});
  assign o_diff = i_minuend[WIDTH-1:0] - i_divisor;

endmodule : div_trial_sub
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_divider                                                      |
// | Radix-2 restoring divider, one quotient bit per cycle, DIV/DIVU. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_last = CW'(WIDTH);

  div_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  // [2W:W] is the current minuend {rem, next dividend bit}; [W-1:0]
  // holds the unshifted dividend bits with quotient bits entering at 0.
  logic [2*WIDTH:0] r_work;
  logic [WIDTH-1:0] r_divisor;
  logic             r_signed;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_abs_a = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs_b = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .i_minuend (r_work[2*WIDTH:WIDTH]),
    .i_divisor (r_divisor),
    .o_diff    (w_diff),
    .o_ge      (w_ge)
  );

  assign w_quot = (r_signed && r_neg_q) ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
  assign w_rem  = (r_signed && r_neg_r) ? -r_work[2*WIDTH:WIDTH+1] : r_work[2*WIDTH:WIDTH+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DivFree;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            r_signed  <= signed_div_i;
            r_neg_q   <= opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1];
            r_neg_r   <= opdata1_i[WIDTH-1];
            r_divisor <= w_abs_b;
            r_work    <= {{WIDTH{1'b0}}, w_abs_a, 1'b0};
            r_cnt     <= '0;
            r_state   <= (opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          if (annul_i) begin
            r_cnt   <= '0;
            r_state <= DivFree;
          end else begin
            result_o <= '0;
            ready_o  <= DivResultReady;
            r_state  <= DivEnd;
          end
        end
        DivOn: begin
          if (annul_i) begin
            r_cnt   <= '0;
            r_state <= DivFree;
          end else if (r_cnt != c_last) begin
            if (w_ge) begin
              r_work <= {w_diff, r_work[WIDTH-1:0], 1'b1};
            end else begin
              r_work <= {r_work[2*WIDTH-1:0], 1'b0};
            end
            r_cnt <= r_cnt + 1'b1;
          end else begin
            result_o <= {w_rem, w_quot};
            ready_o  <= DivResultReady;
            r_state  <= DivEnd;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            r_cnt    <= '0;
            r_state  <= DivFree;
          end
        end
        default: r_state <= DivFree;
      endcase
    end
  end

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seq_divider                                                   |
// | Directed and random checks of seq_divider against an arithmetic  |
// | reference. Revision: 1.0                                         |
// +------------------------------------------------------------------+
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp;
  int n_err;

  seq_divider #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {remainder, quotient} from the language's own truncating division.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready_o && n < 100);
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag, input bit scramble);
    int n;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    if (scramble) begin
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~s;
    end
    wait_ready(n);
    check({tag, " latency"}, 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
    check({tag, " result"}, result_o, exp);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ready_clr"}, 64'(ready_o), 64'd0);
    check({tag, " result_clr"}, result_o, 64'd0);
  endtask

  initial begin
    int n;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "u100/7", 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s-7/2", 1'b0);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC}, "u-7/2", 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, "s_min/-1", 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, "u_max/1", 1'b0);

    // Divide by zero, result held while start stays high
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i = 32'd1234;
    opdata2_i = 32'd0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    wait_ready(n);
    check("byzero latency", 64'(n), 64'd1);
    check("byzero result", result_o, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("byzero hold ready", 64'(ready_o), 64'd1);
      check("byzero hold result", result_o, 64'd0);
    end
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("byzero ready_clr", 64'(ready_o), 64'd0);

    // Annul at iteration 10, then an immediate 50/5 request
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'hDEAD_BEEF;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check("annul ready", 64'(ready_o), 64'd0);
    @(posedge clk);
    #1;
    wait_ready(n);
    check("after_annul latency", 64'(n), 64'd33);
    check("after_annul result", result_o, {32'd0, 32'd10});
    start_i = 1'b0;
    @(posedge clk);
    #1;

    // Reset at iteration 20
    @(negedge clk);
    opdata1_i = 32'd999;
    opdata2_i = 32'd4;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst result", result_o, 64'd0);
    run_op(1'b0, 32'd999, 32'd4, ref_div(1'b0, 32'd999, 32'd4), "after_rst", 1'b0);

    // Random operands, some with inputs scrambled after acceptance
    for (int k = 0; k < 24; k++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        3: b = 32'd0;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(s, a, b, ref_div(s, a, b), $sformatf("rand%0d", k), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seq_divider
`default_nettype wire
